// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: command-driven BCD up/down counter chain controller.
// Define BCD_CTRL_AUTO_RELOAD_EN to reload from ld after terminal count instead of stopping.
module bcd_count_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                tick,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [4*DIGITS-1:0] cmd_data,
    output logic [4*DIGITS-1:0] q,
    output logic                busy,
    output logic                done,
    output logic                tc,
    output logic                err
);
    localparam int W = 4 * DIGITS;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
    state_t state, state_nx;
    logic [W-1:0] q_nx, ld, ld_nx, cnt;
    logic dir, dir_nx, tc_nx, err_nx, accept, c;

    function automatic logic at_term(input logic [W-1:0] v, input logic up);
        at_term = 1'b1;
        for (int i = 0; i < DIGITS; i++) at_term &= v[4*i+:4] == (up ? 4'd9 : 4'd0);
    endfunction

    function automatic logic bad_bcd(input logic [W-1:0] v);
        bad_bcd = 1'b0;
        for (int i = 0; i < DIGITS; i++) bad_bcd |= v[4*i+:4] > 4'd9;
    endfunction

    assign accept = cmd_valid && cmd_ready;

    // ripple carry/borrow through the digit chain
    always_comb begin
        cnt = q;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c)
                cnt[4*i+:4] = dir ? (q[4*i+:4] == 4'd9 ? 4'd0 : q[4*i+:4] + 4'd1)
                                  : (q[4*i+:4] == 4'd0 ? 4'd9 : q[4*i+:4] - 4'd1);
            c = c && (q[4*i+:4] == (dir ? 4'd9 : 4'd0));
        end
    end

    always_comb begin
        state_nx = state;
        q_nx = q;
        ld_nx = ld;
        dir_nx = dir;
        tc_nx = 1'b0;
        err_nx = 1'b0;
        if (accept) begin
            case (cmd_op)
                2'b00: if (state != RUN) begin
                    if (bad_bcd(cmd_data)) err_nx = 1'b1;
                    else begin
                        q_nx = cmd_data;
                        ld_nx = cmd_data;
                        state_nx = IDLE;
                    end
                end
                2'b01: if (state != RUN) begin
                    q_nx = state == DONE ? ld : q;
                    dir_nx = sel;
                    state_nx = RUN;
                    if (at_term(state == DONE ? ld : q, sel)) begin
                        state_nx = DONE;
                        tc_nx = 1'b1;
                    end
                end
                2'b10: state_nx = state == RUN ? HOLD : state;
                default: begin
                    q_nx = '0;
                    ld_nx = '0;
                    dir_nx = 1'b1;
                    state_nx = IDLE;
                end
            endcase
        end else if (tick && state == RUN) begin
`ifdef BCD_CTRL_AUTO_RELOAD_EN
            if (at_term(q, dir)) q_nx = ld;
            else begin
                q_nx = cnt;
                tc_nx = at_term(cnt, dir);
            end
`else
            q_nx = cnt;
            if (at_term(cnt, dir)) begin
                tc_nx = 1'b1;
                state_nx = DONE;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            q <= '0;
            ld <= '0;
            dir <= 1'b1;
            cmd_ready <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            tc <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_nx;
            q <= q_nx;
            ld <= ld_nx;
            dir <= dir_nx;
            cmd_ready <= !accept;
            busy <= state_nx == RUN;
            done <= state_nx == DONE;
            tc <= tc_nx;
            err <= err_nx;
        end
    end
endmodule
